// File: rtl/lightgun_port.sv
// lightgun_port: Genesis controller-port front end for an emulated light gun.
// Synchronises the gun sensors, runs the once-per-frame hit sequence
// (strobe the VDP HL latch, then hold TH low), and builds the pin levels
// returned to the CPU for Menacer or Justifier protocol.
// Optional build macro LIGHTGUN_PORT_DEBOUNCE_EN adds a per-button
// stability filter in front of the port data mux.
module lightgun_port #(
  parameter int HL_WIDTH = 4,
  parameter int TH_HOLD  = 1024,
  parameter int DEBOUNCE = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       JUSTIFIER,
  input  logic       SENSOR1,
  input  logic       SENSOR2,
  input  logic [3:0] BTN1,
  input  logic [3:0] BTN2,
  input  logic       VBLANK,
  input  logic [6:0] PORT_DOUT,
  input  logic [7:0] PORT_CTRL,
  output logic [6:0] PORT_DIN,
  output logic       HL,
  output logic       HIT
);

  typedef enum logic [2:0] {IDLE, ARMED, STROBE, HOLD, DONE} state_t;

  // Bit 0 = gun 1, bit 1 = gun 2.
  logic [1:0]  sens_meta_q, sens_sync_q, sens_prev_q;
  logic [1:0]  sens_rise;
  logic        vb_prev_q, vb_rise, vb_fall;
  logic        gun2_sel, sense_en, hit_cand;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hl_en_q, hl_en_d;
  logic        abort_q, abort_d;
  logic        hit_q, hit_d;
  logic [6:0]  port_din_q, port_din_d;

  logic [7:0]  btn_lvl;  // {gun2 START,C,B,A, gun1 START,C,B,A}
  logic [3:0]  sel_btn;
  logic [6:0]  pin_lvl;

  // Two-flop synchronisers plus an edge-history flop; VBLANK is already synchronous.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sens_meta_q <= '0;
      sens_sync_q <= '0;
      sens_prev_q <= '0;
      vb_prev_q   <= 1'b0;
    end else begin
      sens_meta_q <= {SENSOR2, SENSOR1};
      sens_sync_q <= sens_meta_q;
      sens_prev_q <= sens_sync_q;
      vb_prev_q   <= VBLANK;
    end
  end

  // Gun selection, sensing enable and edge decode.
  always_comb begin
    gun2_sel  = JUSTIFIER & PORT_CTRL[5] & PORT_DOUT[5];
    sense_en  = ~(JUSTIFIER & PORT_CTRL[6] & PORT_DOUT[6]);
    sens_rise = sens_sync_q & ~sens_prev_q;
    hit_cand  = sense_en & (gun2_sel ? sens_rise[1] : sens_rise[0]);
    vb_rise   = VBLANK & ~vb_prev_q;
    vb_fall   = ~VBLANK & vb_prev_q;
  end

  // Frame sequencer: arm on VBLANK fall, accept one hit, strobe HL, hold TH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hl_en_d = hl_en_q;
    abort_d = abort_q;
    hit_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (vb_fall) state_d = ARMED;
      end
      ARMED: begin
        if (vb_rise) begin
          state_d = IDLE;
        end else if (hit_cand) begin
          state_d = STROBE;
          cnt_d   = 16'(HL_WIDTH - 1);
          hit_d   = 1'b1;
          hl_en_d = PORT_CTRL[7];
          abort_d = 1'b0;
        end
      end
      STROBE: begin
        // A frame end during the strobe lets the strobe finish, then skips HOLD.
        if (cnt_q == 16'd0) begin
          if (abort_q || vb_rise) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            cnt_d   = 16'(TH_HOLD - 1);
          end
        end else begin
          cnt_d   = cnt_q - 16'd1;
          abort_d = abort_q | vb_rise;
        end
      end
      HOLD: begin
        if (vb_rise)              state_d = IDLE;
        else if (cnt_q == 16'd0)  state_d = DONE;
        else                      cnt_d   = cnt_q - 16'd1;
      end
      DONE: begin
        if (vb_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hl_en_q <= 1'b0;
      abort_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hl_en_q <= hl_en_d;
      abort_q <= abort_d;
      hit_q   <= hit_d;
    end
  end

`ifdef LIGHTGUN_PORT_DEBOUNCE_EN
  logic [7:0]      btn_raw;
  logic [7:0]      deb_q, deb_d;
  logic [7:0][7:0] dcnt_q, dcnt_d;

  // Per-button filter: level follows the input only after DEBOUNCE steady cycles.
  always_comb begin
    btn_raw = {BTN2, BTN1};
    deb_d   = deb_q;
    dcnt_d  = '0;
    for (int i = 0; i < 8; i++) begin
      if (btn_raw[i] != deb_q[i]) begin
        if (dcnt_q[i] == 8'(DEBOUNCE - 1)) deb_d[i]  = btn_raw[i];
        else                               dcnt_d[i] = dcnt_q[i] + 8'd1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      deb_q  <= '0;
      dcnt_q <= '0;
    end else begin
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign btn_lvl = deb_q;
`else
  assign btn_lvl = {BTN2, BTN1};
`endif

  // Pin levels: active-low buttons, gun-2 flag on D4, TH on D6, outputs read back.
  always_comb begin
    sel_btn    = gun2_sel ? btn_lvl[7:4] : btn_lvl[3:0];
    pin_lvl    = {(state_q != HOLD), 1'b1, (JUSTIFIER ? gun2_sel : 1'b1), ~sel_btn};
    port_din_d = (PORT_CTRL[6:0] & PORT_DOUT) | (~PORT_CTRL[6:0] & pin_lvl);
  end

  // Port data register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) port_din_q <= 7'h7F;
    else          port_din_q <= port_din_d;
  end

  assign PORT_DIN = port_din_q;
  assign HL       = hl_en_q & (state_q == STROBE);
  assign HIT      = hit_q;

endmodule

// File: tb/tb_lightgun_port.sv
// tb_lightgun_port: directed test-plan scenarios followed by random frames.
// A timestamp-based frame model predicts HIT, HL and PORT_DIN every cycle.
module tb_lightgun_port;
  localparam int HLW = 4;
  localparam int THH = 1024;
  localparam int DEB = 16;

  logic       CLK = 0, RESET_N = 0, JUSTIFIER = 0, SENSOR1 = 0, SENSOR2 = 0, VBLANK = 0;
  logic [3:0] BTN1 = 0, BTN2 = 0;
  logic [6:0] PORT_DOUT = 0;
  logic [7:0] PORT_CTRL = 0;
  logic [6:0] PORT_DIN;
  logic       HL, HIT;

  lightgun_port #(.HL_WIDTH(HLW), .TH_HOLD(THH), .DEBOUNCE(DEB)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .JUSTIFIER(JUSTIFIER), .SENSOR1(SENSOR1), .SENSOR2(SENSOR2),
    .BTN1(BTN1), .BTN2(BTN2), .VBLANK(VBLANK), .PORT_DOUT(PORT_DOUT), .PORT_CTRL(PORT_CTRL),
    .PORT_DIN(PORT_DIN), .HL(HL), .HIT(HIT)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model ----
  // Frame view: idle (0), armed (1), fired (2). Once fired, everything is a
  // function of the age since the accepted hit: HL for HLW cycles, TH low for
  // the following THH cycles unless the frame ended during the strobe.
  int       cyc, mode, hit_edge;
  bit       latch, abrt, hold_now, vbp;
  bit [3:0] h1, h2;          // sensor samples, [0] = this edge, [k] = k edges ago
  bit [7:0] dlev;            // filtered button levels
  int       dcnt[8];
  bit [6:0] exp_din;
  bit       exp_hit, exp_hl;

  task automatic model_reset();
    cyc = 0; mode = 0; hit_edge = -1000000; latch = 0; abrt = 0; hold_now = 0; vbp = 0;
    h1 = 0; h2 = 0; dlev = 0;
    for (int i = 0; i < 8; i++) dcnt[i] = 0;
    exp_din = 7'h7F; exp_hit = 0; exp_hl = 0;
  endtask

  task automatic model_step();
    bit vrise, vfall, gun2, sense, srise, hold_prev;
    bit [7:0] raw, lvl;
    bit [3:0] b;
    bit [6:0] pins;
    int age;
    if (!RESET_N) begin model_reset(); return; end
    cyc++;
    h1 = {h1[2:0], SENSOR1};
    h2 = {h2[2:0], SENSOR2};
    vrise = VBLANK && !vbp;
    vfall = !VBLANK && vbp;
    vbp   = VBLANK;
    gun2  = JUSTIFIER && PORT_CTRL[5] && PORT_DOUT[5];
    sense = !(JUSTIFIER && PORT_CTRL[6] && PORT_DOUT[6]);
    srise = gun2 ? (h2[2] && !h2[3]) : (h1[2] && !h1[3]);
    hold_prev = hold_now;

    raw = {BTN2, BTN1};
`ifdef LIGHTGUN_PORT_DEBOUNCE_EN
    lvl = dlev;
    for (int i = 0; i < 8; i++) begin
      if (raw[i] != dlev[i]) begin
        dcnt[i]++;
        if (dcnt[i] >= DEB) begin dlev[i] = raw[i]; dcnt[i] = 0; end
      end else dcnt[i] = 0;
    end
`else
    lvl = raw;
`endif
    b = gun2 ? lvl[7:4] : lvl[3:0];
    pins = {!hold_prev, 1'b1, (JUSTIFIER ? gun2 : 1'b1), ~b};
    exp_din = (PORT_CTRL[6:0] & PORT_DOUT) | (~PORT_CTRL[6:0] & pins);

    case (mode)
      0: if (vfall) mode = 1;
      1: begin
        if (vrise) mode = 0;
        else if (sense && srise) begin
          mode = 2; hit_edge = cyc; latch = PORT_CTRL[7]; abrt = 0;
        end
      end
      default: begin
        age = cyc - hit_edge;
        if (age <= HLW) begin
          if (vrise) abrt = 1;
          if (age == HLW && abrt) mode = 0;
        end else if (vrise) mode = 0;
      end
    endcase
    age      = cyc - hit_edge;
    exp_hit  = (mode == 2) && (age == 0);
    exp_hl   = (mode == 2) && latch && (age < HLW);
    hold_now = (mode == 2) && !abrt && (age >= HLW) && (age < HLW + THH);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    chk("hit", HIT, exp_hit);
    chk("hl", HL, exp_hl);
    chk("port_din", PORT_DIN, exp_din);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic new_frame();
    VBLANK = 1; run(6);
    VBLANK = 0; run(6);
  endtask

  task automatic pulse1(); SENSOR1 = 1; run(8); SENSOR1 = 0; endtask
  task automatic pulse2(); SENSOR2 = 1; run(8); SENSOR2 = 0; endtask

  task automatic wait_hl(input int max);
    for (int i = 0; i < max && !HL; i++) cycle();
    chk("hl_reached", HL, 1);
  endtask

  task automatic async_reset();
    #1 RESET_N = 0;
    #1;
    chk("rst_din", PORT_DIN, 7'h7F);
    chk("rst_hl", HL, 0);
    chk("rst_hit", HIT, 0);
    model_reset();
    run(3);
    RESET_N = 1;
  endtask

  initial begin
    model_reset();
    RESET_N = 0;
    run(3);
    RESET_N = 1;
    run(2);

    // Menacer hit with latch enabled, then a second edge in the same frame.
    PORT_CTRL = 8'h80;
    new_frame();
    pulse1(); run(1100);
    run(880);
    pulse1(); run(20);
    new_frame();
    pulse1(); run(1100);

    // Latch disabled.
    PORT_CTRL = 8'h00;
    new_frame();
    pulse1(); run(1100);

    // Justifier: gun 2 selected through bit 5, A pressed on gun 2.
    JUSTIFIER = 1; PORT_CTRL = 8'h60; PORT_DOUT = 7'h20; BTN2 = 4'b0001;
    new_frame();
    pulse1(); run(20);
    chk("jus_d4", PORT_DIN[4], 1);
    chk("jus_d0", PORT_DIN[0], 0);
    pulse2(); run(1100);
    new_frame();
    PORT_DOUT = 7'h60;
    pulse2(); run(20);

    // Frame ends two cycles into the strobe.
    JUSTIFIER = 0; PORT_CTRL = 8'h80; PORT_DOUT = 7'h00; BTN2 = 0;
    new_frame();
    SENSOR1 = 1;
    for (int i = 0; i < 10 && !HIT; i++) cycle();
    chk("hit_seen", HIT, 1);
    cycle();
    VBLANK = 1; run(10);
    chk("hl_after_abort", HL, 0);
    VBLANK = 0; SENSOR1 = 0; run(1100);

    // Reset mid-HOLD and mid-strobe.
    new_frame();
    pulse1(); run(100);
    chk("th_in_hold", PORT_DIN[6], 0);
    async_reset();
    run(2);
    new_frame();
    SENSOR1 = 1;
    wait_hl(20);
    async_reset();
    SENSOR1 = 0;
    run(4);

`ifdef LIGHTGUN_PORT_DEBOUNCE_EN
    // Short glitch is filtered; a long press gets through.
    BTN1 = 4'b0001; run(10);
    chk("deb_short", PORT_DIN[0], 1);
    BTN1 = 4'b0000; run(5);
    BTN1 = 4'b0001; run(20);
    chk("deb_long", PORT_DIN[0], 0);
    BTN1 = 4'b0000; run(20);
`endif

    // Random frames.
    for (int f = 0; f < 14; f++) begin
      JUSTIFIER = 1'($urandom_range(0, 1));
      PORT_CTRL = 8'($urandom);
      PORT_DOUT = 7'($urandom);
      VBLANK = 1;
      for (int i = 0, k = $urandom_range(3, 30); i < k; i++) cycle();
      VBLANK = 0;
      for (int i = 0, k = $urandom_range(300, 2500); i < k; i++) begin
        cycle();
        if ($urandom_range(0, 149) == 0) SENSOR1 = ~SENSOR1;
        if ($urandom_range(0, 149) == 0) SENSOR2 = ~SENSOR2;
        if ($urandom_range(0, 63) == 0)  BTN1 = 4'($urandom);
        if ($urandom_range(0, 63) == 0)  BTN2 = 4'($urandom);
        if ($urandom_range(0, 399) == 0) PORT_DOUT = 7'($urandom);
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
